n64_vparams_ctrl: RTL and testbench



---
 rtl/n64_vparams_ctrl_pkg.sv | 36 +++
 rtl/n64_vparams_ctrl_vinfo_det.sv | 141 ++++++++++++++
 rtl/n64_vparams_ctrl.sv | 115 +++++++++++
 tb/tb_n64_vparams_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/n64_vparams_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : n64_vparams_ctrl_pkg
// Purpose  : Shared constants for the N64 video demux parameter controller.
//            Covers demuxparams bit positions, deblur mode encodings, sync
//            nibble bit indices and the default PAL line threshold.
// Revision : 1.0 - initial release
// ============================================================================
package n64_vparams_ctrl_pkg;

  // Bit positions inside demuxparams {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}
  localparam int DATA_CNT_HI = 4;
  localparam int DATA_CNT_LO = 3;
  localparam int VMODE_BIT   = 2;
  localparam int NDEBLUR_BIT = 1;
  localparam int N15BIT_BIT  = 0;

  // Deblur mode encodings; both 00 and 11 select automatic behaviour
  typedef enum logic [1:0] {
    DEBLUR_AUTO     = 2'b00,
    DEBLUR_OFF      = 2'b01,
    DEBLUR_ON       = 2'b10,
    DEBLUR_AUTO_ALT = 2'b11
  } deblur_mode_e;

  // Bit indices of the sync nibble {nVSYNC, nCLAMP, nHSYNC, nCSYNC}
  localparam int SYNC_NVSYNC = 3;
  localparam int SYNC_NCLAMP = 2;
  localparam int SYNC_NHSYNC = 1;
  localparam int SYNC_NCSYNC = 0;

  // Lines per field strictly above which the source is treated as PAL
  localparam int unsigned PAL_LINE_THRESH_DEF = 300;

endpackage : n64_vparams_ctrl_pkg
`default_nettype wire

// File: rtl/n64_vparams_ctrl_vinfo_det.sv
`default_nettype none
// ============================================================================
// Module   : n64_vinfo_det
// Purpose  : Video format detector. Samples the sync nibble on nDSYNC-low
//            cycles, counts pixels per line and lines per field, and on each
//            nVSYNC falling edge reports PAL/NTSC and 240p/480i.
// Ports    : VCLK, nRST        - clock, synchronous active-low reset
//            nDSYNC, D_i       - N64 data sync and sync nibble
//            vmode_cur_i       - currently latched vmode (filter hold value)
//            n480i_cur_i       - currently latched n64_480i (filter hold value)
//            field_evt_o       - field event (nVSYNC falling edge) this cycle
//            vmode_new_o       - vmode to latch at the field event
//            n480i_new_o       - n64_480i to latch at the field event
// Config   : VMODE_FILTER_EN   - when defined, a new vmode/n64_480i value is
//            accepted only once two consecutive fields agree on it.
// Revision : 1.0 - initial release
// ============================================================================
module n64_vinfo_det
  import n64_vparams_ctrl_pkg::*;
#(
  parameter int          LINE_CNT_W      = 10,
  parameter int          HPOS_CNT_W      = 10,
  parameter int unsigned PAL_LINE_THRESH = PAL_LINE_THRESH_DEF
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [3:0] D_i,
  input  logic       vmode_cur_i,
  input  logic       n480i_cur_i,
  output logic       field_evt_o,
  output logic       vmode_new_o,
  output logic       n480i_new_o
);

  logic [3:0]            sync_q, sync_d;
  logic [HPOS_CNT_W-1:0] hpos_q, hpos_d;
  logic [HPOS_CNT_W-1:0] hpos_prev_q, hpos_prev_d;
  logic                  prev_valid_q, prev_valid_d;
  logic [LINE_CNT_W-1:0] line_q, line_d;

  logic                  w_hs_fall;
  logic                  w_vs_fall;
  logic [LINE_CNT_W-1:0] w_line_eval;
  logic                  w_vmode_det;
  logic                  w_n480i_det;

  // Clamp and composite sync are stored with the nibble but not evaluated here
  logic unused_sync_bits;
  assign unused_sync_bits = sync_q[SYNC_NCLAMP] ^ sync_q[SYNC_NCSYNC];

  always_comb begin
    w_hs_fall = ~nDSYNC & sync_q[SYNC_NHSYNC] & ~D_i[SYNC_NHSYNC];
    w_vs_fall = ~nDSYNC & sync_q[SYNC_NVSYNC] & ~D_i[SYNC_NVSYNC];

    // A line starting in the same sample as the field event belongs to the
    // field being closed, so it is counted before the threshold compare.
    w_line_eval = line_q;
    if (w_hs_fall && (line_q != {LINE_CNT_W{1'b1}})) begin
      w_line_eval = line_q + 1'b1;
    end

    w_vmode_det = (w_line_eval > LINE_CNT_W'(PAL_LINE_THRESH));
    // Interlace shows up as vsync landing at a different pixel position in
    // alternate fields; with no earlier field there is nothing to compare.
    w_n480i_det = prev_valid_q & (hpos_q != hpos_prev_q);

    sync_d       = sync_q;
    hpos_d       = hpos_q;
    hpos_prev_d  = hpos_prev_q;
    prev_valid_d = prev_valid_q;
    line_d       = w_vs_fall ? '0 : w_line_eval;

    if (!nDSYNC) begin
      sync_d = D_i;
      if (w_hs_fall) begin
        hpos_d = '0;
      end else if (hpos_q != {HPOS_CNT_W{1'b1}}) begin
        hpos_d = hpos_q + 1'b1;
      end
    end

    if (w_vs_fall) begin
      hpos_prev_d  = hpos_q;
      prev_valid_d = 1'b1;
    end
  end

`ifdef VMODE_FILTER_EN
  logic vdet_prev_q, vdet_prev_d;
  logic idet_prev_q, idet_prev_d;

  always_comb begin
    vdet_prev_d = vdet_prev_q;
    idet_prev_d = idet_prev_q;
    if (w_vs_fall) begin
      vdet_prev_d = w_vmode_det;
      idet_prev_d = w_n480i_det;
    end
    // Accept a detected value only when the previous field saw the same;
    // otherwise keep what is currently latched.
    vmode_new_o = (w_vmode_det == vdet_prev_q) ? w_vmode_det : vmode_cur_i;
    n480i_new_o = (w_n480i_det == idet_prev_q) ? w_n480i_det : n480i_cur_i;
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      vdet_prev_q <= 1'b0;
      idet_prev_q <= 1'b0;
    end else begin
      vdet_prev_q <= vdet_prev_d;
      idet_prev_q <= idet_prev_d;
    end
  end
`else
  logic unused_cur;
  assign unused_cur  = vmode_cur_i ^ n480i_cur_i;
  assign vmode_new_o = w_vmode_det;
  assign n480i_new_o = w_n480i_det;
`endif

  assign field_evt_o = w_vs_fall;

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      sync_q       <= 4'hF;
      hpos_q       <= '0;
      hpos_prev_q  <= '0;
      prev_valid_q <= 1'b0;
      line_q       <= '0;
    end else begin
      sync_q       <= sync_d;
      hpos_q       <= hpos_d;
      hpos_prev_q  <= hpos_prev_d;
      prev_valid_q <= prev_valid_d;
      line_q       <= line_d;
    end
  end

endmodule : n64_vinfo_det
`default_nettype wire

// File: rtl/n64_vparams_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : n64_vparams_ctrl
// Purpose  : Sequencer and configuration controller for the N64 video demux.
//            Generates the per-VCLK data phase counter, and at each field
//            event latches detected format plus user settings into the
//            5-bit demux parameter word.
// Ports    : VCLK, nRST          - clock, synchronous active-low reset
//            nDSYNC, D_i         - N64 data sync and sync nibble
//            cfg_deblur_mode_i   - 00/11 auto, 01 force off, 10 force on
//            cfg_n15bit_i        - 1 = 21-bit colour, 0 = 15-bit colour
//            demuxparams_o       - {data_cnt[1:0], vmode, ndo_deblur, n15bit_mode}
//            vinfo_o             - {vmode, n64_480i}
//            frame_stb_o         - one-cycle pulse after each field event
// Config   : VMODE_FILTER_EN     - enables two-field agreement on vmode/480i
// Revision : 1.0 - initial release
// ============================================================================
module n64_vparams_ctrl
  import n64_vparams_ctrl_pkg::*;
#(
  parameter int          LINE_CNT_W      = 10,
  parameter int          HPOS_CNT_W      = 10,
  parameter int unsigned PAL_LINE_THRESH = PAL_LINE_THRESH_DEF
) (
  input  logic       VCLK,
  input  logic       nRST,
  input  logic       nDSYNC,
  input  logic [3:0] D_i,
  input  logic [1:0] cfg_deblur_mode_i,
  input  logic       cfg_n15bit_i,
  output logic [4:0] demuxparams_o,
  output logic [1:0] vinfo_o,
  output logic       frame_stb_o
);

  logic [1:0] data_cnt_q, data_cnt_d;
  logic       vmode_q, vmode_d;
  logic       n480i_q, n480i_d;
  logic       ndeblur_q, ndeblur_d;
  logic       n15bit_q, n15bit_d;
  logic       stb_q, stb_d;

  logic       w_field_evt;
  logic       w_vmode_new;
  logic       w_n480i_new;

  n64_vinfo_det #(
    .LINE_CNT_W      (LINE_CNT_W),
    .HPOS_CNT_W      (HPOS_CNT_W),
    .PAL_LINE_THRESH (PAL_LINE_THRESH)
  ) u_vinfo_det (
    .VCLK        (VCLK),
    .nRST        (nRST),
    .nDSYNC      (nDSYNC),
    .D_i         (D_i),
    .vmode_cur_i (vmode_q),
    .n480i_cur_i (n480i_q),
    .field_evt_o (w_field_evt),
    .vmode_new_o (w_vmode_new),
    .n480i_new_o (w_n480i_new)
  );

  always_comb begin
    // Phase 00 is the idle/sync slot: the counter parks there until the next
    // sync nibble restarts it at 01 (red).
    data_cnt_d = data_cnt_q;
    if (!nDSYNC) begin
      data_cnt_d = 2'b01;
    end else if (data_cnt_q != 2'b00) begin
      data_cnt_d = data_cnt_q + 2'b01;
    end

    vmode_d   = vmode_q;
    n480i_d   = n480i_q;
    ndeblur_d = ndeblur_q;
    n15bit_d  = n15bit_q;
    stb_d     = w_field_evt;

    // All format-dependent outputs change together, only at field boundaries
    if (w_field_evt) begin
      vmode_d   = w_vmode_new;
      n480i_d   = w_n480i_new;
      // Deblur is never applied to interlaced content, even when forced on
      ndeblur_d = (deblur_mode_e'(cfg_deblur_mode_i) == DEBLUR_OFF) | w_n480i_new;
      n15bit_d  = cfg_n15bit_i;
    end
  end

  always_ff @(posedge VCLK) begin
    if (!nRST) begin
      data_cnt_q <= 2'b00;
      vmode_q    <= 1'b0;
      n480i_q    <= 1'b0;
      ndeblur_q  <= 1'b1;
      n15bit_q   <= 1'b1;
      stb_q      <= 1'b0;
    end else begin
      data_cnt_q <= data_cnt_d;
      vmode_q    <= vmode_d;
      n480i_q    <= n480i_d;
      ndeblur_q  <= ndeblur_d;
      n15bit_q   <= n15bit_d;
      stb_q      <= stb_d;
    end
  end

  assign demuxparams_o[DATA_CNT_HI:DATA_CNT_LO] = data_cnt_q;
  assign demuxparams_o[VMODE_BIT]               = vmode_q;
  assign demuxparams_o[NDEBLUR_BIT]             = ndeblur_q;
  assign demuxparams_o[N15BIT_BIT]              = n15bit_q;
  assign vinfo_o                                = {vmode_q, n480i_q};
  assign frame_stb_o                            = stb_q;

endmodule : n64_vparams_ctrl
`default_nettype wire

// File: tb/tb_n64_vparams_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_n64_vparams_ctrl
// Purpose  : Self-checking bench for n64_vparams_ctrl. A stimulus process
//            generates video fields at the line/field level and pushes the
//            expected output word for every clock into a queue; a monitor
//            process pops one entry per clock and compares it to the DUT.
// Config   : VMODE_FILTER_EN - model follows the two-field agreement rule
// Revision : 1.0 - initial release
// ============================================================================
module tb_n64_vparams_ctrl;

  logic       VCLK = 1'b0;
  logic       nRST = 1'b0;
  logic       nDSYNC = 1'b1;
  logic [3:0] D_i = 4'hF;
  logic [1:0] cfg_deblur_mode_i = 2'b00;
  logic       cfg_n15bit_i = 1'b1;
  logic [4:0] demuxparams_o;
  logic [1:0] vinfo_o;
  logic       frame_stb_o;

  n64_vparams_ctrl dut (
    .VCLK              (VCLK),
    .nRST              (nRST),
    .nDSYNC            (nDSYNC),
    .D_i               (D_i),
    .cfg_deblur_mode_i (cfg_deblur_mode_i),
    .cfg_n15bit_i      (cfg_n15bit_i),
    .demuxparams_o     (demuxparams_o),
    .vinfo_o           (vinfo_o),
    .frame_stb_o       (frame_stb_o)
  );

  always #5 VCLK = ~VCLK;

  int vectors     = 0;
  int miscompares = 0;
  int cyc_no      = 0;

  logic [7:0] exp_q[$];

  // Reference model state (field-level view of the video stream)
  int   m_dc;
  bit   m_vm, m_i, m_nd, m_n15, m_stb;
  int   prev_h;
  bit   prev_valid;
  bit   fv_prev, fi_prev;
  logic [1:0] tb_deblur = 2'b00;
  bit   tb_n15 = 1'b1;

  task automatic model_reset();
    m_dc = 0; m_vm = 0; m_i = 0; m_nd = 1; m_n15 = 1; m_stb = 0;
    prev_valid = 0; prev_h = 0; fv_prev = 0; fi_prev = 0;
  endtask

  // One VCLK of stimulus. evt marks the sample that closes a field of
  // 'lines' lines whose vsync arrived at pixel position 'h'.
  task automatic drive(input bit rn, input bit nds, input logic [3:0] d,
                       input bit evt, input int lines, input int h);
    bit det_v, det_i;
    logic [1:0] dcv;
    @(negedge VCLK);
    nRST = rn; nDSYNC = nds; D_i = d;
    cfg_deblur_mode_i = tb_deblur; cfg_n15bit_i = tb_n15;
    if (!rn) begin
      model_reset();
    end else begin
      if (!nds)           m_dc = 1;
      else if (m_dc != 0) m_dc = (m_dc + 1) % 4;
      m_stb = evt;
      if (evt) begin
        det_v = (lines > 300);
        det_i = prev_valid && (h != prev_h);
`ifdef VMODE_FILTER_EN
        if (det_v == fv_prev) m_vm = det_v;
        if (det_i == fi_prev) m_i = det_i;
        fv_prev = det_v; fi_prev = det_i;
`else
        m_vm = det_v; m_i = det_i;
`endif
        prev_h = h; prev_valid = 1;
        m_nd  = (tb_deblur == 2'b01) || m_i;
        m_n15 = tb_n15;
      end
    end
    dcv = m_dc[1:0];
    exp_q.push_back({dcv, m_vm, m_nd, m_n15, m_vm, m_i, m_stb});
  endtask

  // A sync sample followed by 'gaps' data cycles (-1: random 0..1)
  task automatic send(input logic [3:0] nib, input bit evt, input int lines,
                      input int h, input int gaps);
    int n;
    drive(1'b1, 1'b0, nib, evt, lines, h);
    n = (gaps < 0) ? int'($urandom_range(0, 1)) : gaps;
    for (int g = 0; g < n; g++) drive(1'b1, 1'b1, 4'($urandom), 1'b0, 0, 0);
  endtask

  // Field of L lines (4 samples each, nHSYNC low on the first). In the last
  // line nVSYNC falls at sample p (p=0 coincides with the line's nHSYNC fall).
  // mid: 0 none, 1 randomise cfg mid-field, 2 drop cfg_n15bit mid-field.
  task automatic field(input int L, input int p, input int mid);
    int h, len;
    bit last, vs, hs;
    logic [3:0] nib;
    h = (p == 0) ? 3 : p - 1;
    for (int i = 0; i < L; i++) begin
      last = (i == L - 1);
      len  = last ? p + 3 : 4;
      if (i == L / 2) begin
        if (mid == 1) begin tb_deblur = 2'($urandom); tb_n15 = 1'($urandom); end
        if (mid == 2) tb_n15 = 1'b0;
      end
      for (int s = 0; s < len; s++) begin
        vs  = !(last && s >= p);
        hs  = (s != 0);
        nib = {vs, 1'($urandom), hs, 1'($urandom)};
        send(nib, last && (s == p), L, h, -1);
      end
    end
  endtask

  // Monitor: one expected word per clock, checked away from the edge
  initial begin
    logic [7:0] e, got;
    forever begin
      @(posedge VCLK);
      #1;
      cyc_no++;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        got = {demuxparams_o, vinfo_o, frame_stb_o};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL out_word cycle %0d: got demux=%b vinfo=%b stb=%b, expected demux=%b vinfo=%b stb=%b",
                   cyc_no, got[7:3], got[2:1], got[0], e[7:3], e[2:1], e[0]);
        end
      end
    end
  end

  initial begin
    model_reset();
    repeat (3) drive(1'b0, 1'b1, 4'hF, 1'b0, 0, 0);

    // Data phase: sync then three data cycles
    repeat (4) send(4'hF, 1'b0, 0, 0, 3);

    // NTSC progressive, auto deblur
    tb_deblur = 2'b00; tb_n15 = 1'b1;
    field(263, 10, 0);
    field(263, 10, 0);
    // PAL
    field(313, 10, 0);
    // Alternating vsync position, deblur forced on
    tb_deblur = 2'b10;
    field(263, 10, 0);
    field(263, 400, 0);
    field(263, 10, 0);
    // Colour depth change mid-field
    field(263, 400, 2);
    field(263, 10, 0);
    tb_n15 = 1'b1;

    // Reset in the middle of a field
    for (int i = 0; i < 20; i++)
      for (int s = 0; s < 4; s++) send({1'b1, 1'b1, (s != 0), 1'b1}, 1'b0, 0, 0, -1);
    repeat (2) drive(1'b0, 1'b1, 4'hF, 1'b0, 0, 0);
    field(263, 10, 0);
    field(263, 40, 0);

    // Isolated PAL field inside an NTSC stream, then two PAL fields
    tb_deblur = 2'b00;
    field(263, 5, 0);
    field(263, 5, 0);
    field(313, 5, 0);
    field(263, 5, 0);
    field(313, 5, 0);
    field(313, 5, 0);

    // Threshold boundary and simultaneous hsync/vsync edges
    field(300, 7, 0);
    field(300, 7, 0);
    field(301, 7, 0);
    field(301, 0, 0);
    field(300, 0, 0);
    field(300, 0, 0);

    // Randomised fields
    repeat (6) field(int'($urandom_range(250, 350)), int'($urandom_range(0, 450)), 1);

    // Sync loss: line counter saturates, nothing changes until vsync
    field(1100, 5, 0);

    repeat (5) drive(1'b1, 1'b1, 4'hF, 1'b0, 0, 0);
    repeat (3) @(negedge VCLK);

    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_n64_vparams_ctrl
`default_nettype wire
